// File: rtl/data_memory_responder.sv
// MEM-stage data-memory responder: word RAM behind a fixed-latency FSM, RISC-V byte/half/word access.
// Optional per-access counters via `define DMEM_ACCESS_COUNTERS_EN (adds READ_COUNT / WRITE_COUNT).
module data_memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MEM_ERROR
`ifdef DMEM_ACCESS_COUNTERS_EN
  ,
  output logic [31:0] READ_COUNT,
  output logic [31:0] WRITE_COUNT
`endif
);
  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESPOND = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [31:0]           mem_q [DEPTH];

  logic [31:0] word, ld_shift, ld_val, st_mask, wr_word;
  logic [4:0]  sh;
  logic        fmt_err, conflict, access_now, do_write;
  logic        unused_addr;

  // Upper address bits are deliberately dropped so accesses wrap within the RAM.
  assign unused_addr = |ADDRESS[31:ADDR_WIDTH];

  assign BUSYWAIT  = (MEM_READ | MEM_WRITE) & (state_q != RESPOND);
  assign READ_DATA = rdata_q;
  assign MEM_ERROR = err_q;

  always_comb begin
    word     = mem_q[addr_q[ADDR_WIDTH-1:2]];
    sh       = {addr_q[1:0], 3'b000};
    ld_shift = word >> sh;
    conflict = rd_q & wr_q;
    unique case (f3_q)
      3'b000:         fmt_err = 1'b0;
      3'b001:         fmt_err = addr_q[0];
      3'b010:         fmt_err = |addr_q[1:0];
      3'b100, 3'b101: fmt_err = ~rd_q | (f3_q[0] & addr_q[0]);  // unsigned forms are load-only
      default:        fmt_err = 1'b1;
    endcase
    unique case (f3_q)
      3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_val = {24'h0, ld_shift[7:0]};
      3'b101:  ld_val = {16'h0, ld_shift[15:0]};
      default: ld_val = ld_shift;
    endcase
    unique case (f3_q[1:0])
      2'b00:   st_mask = 32'h0000_00FF << sh;
      2'b01:   st_mask = 32'h0000_FFFF << sh;
      default: st_mask = 32'hFFFF_FFFF;
    endcase
    wr_word    = (word & ~st_mask) | ((wdata_q << sh) & st_mask);
    access_now = (state_q == WAIT) && (cnt_q == 4'd0);
    do_write   = access_now & wr_q & ~rd_q & ~fmt_err;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (MEM_READ | MEM_WRITE) begin
        rd_d    = MEM_READ;
        wr_d    = MEM_WRITE;
        f3_d    = FUNCT3;
        addr_d  = ADDRESS[ADDR_WIDTH-1:0];
        wdata_d = WRITE_DATA;
        cnt_d   = 4'(LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d = RESPOND;
        err_d   = fmt_err | conflict;
        if (rd_q | fmt_err) rdata_d = fmt_err ? 32'h0 : ld_val;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is not reset; an abandoned access never writes because reset forces the FSM out of WAIT.
  always_ff @(posedge CLK) begin
    if (do_write) mem_q[addr_q[ADDR_WIDTH-1:2]] <= wr_word;
  end

`ifdef DMEM_ACCESS_COUNTERS_EN
  logic [31:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic        ok_access;

  always_comb begin
    ok_access = access_now & ~fmt_err & ~conflict;
    rcnt_d    = rcnt_q + {31'h0, ok_access & rd_q};
    wcnt_d    = wcnt_q + {31'h0, ok_access & wr_q};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rcnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign READ_COUNT  = rcnt_q;
  assign WRITE_COUNT = wcnt_q;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder against a byte-array reference model.
module tb_data_memory_responder;
  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        RESET, MEM_READ, MEM_WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDRESS, WRITE_DATA, READ_DATA;
  logic        BUSYWAIT, MEM_ERROR;
`ifdef DMEM_ACCESS_COUNTERS_EN
  logic [31:0] READ_COUNT, WRITE_COUNT;
`endif

  int n_tests = 0, n_fail = 0;
  int exp_rc = 0, exp_wc = 0;
  logic [7:0] m [1024];

  always #5 CLK = ~CLK;

  data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .FUNCT3(FUNCT3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
    .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MEM_ERROR(MEM_ERROR)
`ifdef DMEM_ACCESS_COUNTERS_EN
    , .READ_COUNT(READ_COUNT), .WRITE_COUNT(WRITE_COUNT)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit bad_fmt(bit isld, logic [2:0] f3, logic [31:0] a);
    case (f3)
      3'd0:    return 1'b0;
      3'd1:    return a[0];
      3'd2:    return a[1:0] != 2'b00;
      3'd4:    return !isld;
      3'd5:    return !isld || a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a);
    int b;
    logic [15:0] h;
    b = int'(a[9:0]);
    case (f3)
      3'd0: return {{24{m[b][7]}}, m[b]};
      3'd4: return {24'h0, m[b]};
      3'd1, 3'd5: begin
        h = {m[b+1], m[b]};
        return (f3 == 3'd1) ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: return {m[b+3], m[b+2], m[b+1], m[b]};
    endcase
  endfunction

  function automatic void model_store(logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    int b;
    b = int'(a[9:0]);
    m[b] = wd[7:0];
    if (f3 != 3'd0) m[b+1] = wd[15:8];
    if (f3 == 3'd2) begin
      m[b+2] = wd[23:16];
      m[b+3] = wd[31:24];
    end
  endfunction

  // Starts at a negedge with the DUT idle (or in RESPOND when from_resp); returns at a negedge.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, input bit from_resp,
                        output logic [31:0] obs);
    bit bad, err;
    logic [31:0] exp_rd;
    int n;
    bad    = bad_fmt(rd, f3, a);
    err    = bad || (rd && wr);
    exp_rd = (rd && !bad) ? model_load(f3, a) : 32'h0;
    MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = a; WRITE_DATA = wd;
    if (from_resp) begin
      @(posedge CLK); @(negedge CLK);
      chk("busy_in_idle", {31'h0, BUSYWAIT}, 32'd1);
    end
    @(posedge CLK);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      n++;
    end
    chk("busy_cycles", n, LAT);
    chk("mem_error", {31'h0, MEM_ERROR}, {31'h0, err});
    if (rd) chk("read_data", READ_DATA, exp_rd);
    obs = READ_DATA;
    if (!err) begin
      if (wr) begin model_store(f3, a, wd); exp_wc++; end
      else exp_rc++;
    end
    if (!hold) begin
      MEM_READ = 1'b0; MEM_WRITE = 1'b0;
      @(posedge CLK); @(negedge CLK);
      chk("err_after_resp", {31'h0, MEM_ERROR}, 32'd0);
    end
  endtask

  task automatic chk_counts();
`ifdef DMEM_ACCESS_COUNTERS_EN
    chk("read_count", READ_COUNT, exp_rc);
    chk("write_count", WRITE_COUNT, exp_wc);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] o, a, wd;
    logic [2:0] f3;
    bit rd, wr, hold, prev_hold;
    int op;

    RESET = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    FUNCT3 = '0; ADDRESS = '0; WRITE_DATA = '0;
    repeat (3) @(negedge CLK);
    chk("rst_read_data", READ_DATA, 32'h0);
    chk("rst_mem_error", {31'h0, MEM_ERROR}, 32'd0);
    chk("rst_busywait", {31'h0, BUSYWAIT}, 32'd0);
    chk_counts();
    RESET = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 256; i++) access(0, 1, 3'd2, i * 4, $urandom, 0, 0, o);

    access(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0, o);
    access(1, 0, 3'd2, 32'h10, 32'h0, 0, 0, o);  chk("lw_10", o, 32'hDEADBEEF);
    access(0, 1, 3'd0, 32'h13, 32'h7F, 0, 0, o);
    access(1, 0, 3'd0, 32'h13, 32'h0, 0, 0, o);  chk("lb_13", o, 32'h0000007F);
    access(1, 0, 3'd0, 32'h10, 32'h0, 0, 0, o);  chk("lb_10", o, 32'hFFFFFFEF);
    access(1, 0, 3'd4, 32'h10, 32'h0, 0, 0, o);  chk("lbu_10", o, 32'h000000EF);
    access(1, 0, 3'd5, 32'h12, 32'h0, 0, 0, o);  chk("lhu_12", o, 32'h00007FAD);
    access(1, 0, 3'd2, 32'h11, 32'h0, 0, 0, o);  chk("lw_mis", o, 32'h0);
    access(1, 0, 3'd2, 32'h10, 32'h0, 0, 0, o);  chk("lw_10_kept", o, 32'h7FADBEEF);
    access(0, 1, 3'd1, 32'h13, 32'h5555, 0, 0, o);
    access(1, 0, 3'd2, 32'h10, 32'h0, 0, 0, o);  chk("sh_mis_nowr", o, 32'h7FADBEEF);
    access(0, 1, 3'd2, 32'h404, 32'h12345678, 0, 0, o);
    access(1, 0, 3'd2, 32'h004, 32'h0, 0, 0, o); chk("wrap_lw", o, 32'h12345678);
    access(1, 1, 3'd2, 32'h004, 32'h0BADF00D, 0, 0, o);
    access(1, 0, 3'd2, 32'h004, 32'h0, 0, 0, o); chk("conflict_nowr", o, 32'h12345678);

    // Reset while the SW to 0x20 is in WAIT with two cycles left on the counter.
    MEM_READ = 1'b0; MEM_WRITE = 1'b1; FUNCT3 = 3'd2; ADDRESS = 32'h20; WRITE_DATA = 32'hAAAAAAAA;
    @(posedge CLK); @(posedge CLK);
    #1 RESET = 1'b0; MEM_WRITE = 1'b0;
    #1 chk("busy_rst", {31'h0, BUSYWAIT}, 32'd0);
    @(negedge CLK);
    chk("rst2_read_data", READ_DATA, 32'h0);
    chk("rst2_mem_error", {31'h0, MEM_ERROR}, 32'd0);
    RESET = 1'b1;
    exp_rc = 0; exp_wc = 0;
    chk_counts();
    @(negedge CLK);

    access(1, 0, 3'd2, 32'h20, 32'h0, 1, 0, o);
    access(0, 1, 3'd2, 32'h24, 32'hCAFEF00D, 0, 1, o);
    chk_counts();
    access(1, 0, 3'd2, 32'h20, 32'h0, 0, 0, o);
    access(1, 0, 3'd2, 32'h24, 32'h0, 0, 0, o);  chk("b2b_sw", o, 32'hCAFEF00D);

    // Request withdrawn after one WAIT cycle still commits.
    MEM_READ = 1'b0; MEM_WRITE = 1'b1; FUNCT3 = 3'd2; ADDRESS = 32'h30; WRITE_DATA = 32'h600DCAFE;
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    MEM_WRITE = 1'b0;
    repeat (LAT + 2) @(posedge CLK);
    @(negedge CLK);
    model_store(3'd2, 32'h30, 32'h600DCAFE);
    exp_wc++;
    access(1, 0, 3'd2, 32'h30, 32'h0, 0, 0, o);  chk("drop_commit", o, 32'h600DCAFE);

    prev_hold = 1'b0;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      rd = (op < 5) || (op == 9);
      wr = (op >= 5);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) f3 = {1'b0, 2'($urandom_range(0, 2))};
      a = $urandom & 32'hFFF;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wd = $urandom;
      hold = ($urandom_range(0, 3) == 0);
      access(rd, wr, f3, a, wd, hold, prev_hold, o);
      prev_hold = hold;
    end
    if (prev_hold) begin
      MEM_READ = 1'b0; MEM_WRITE = 1'b0;
      @(posedge CLK); @(negedge CLK);
    end
    chk_counts();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
